serial_adder: RTL



---
 rtl/serial_adder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder built around a single full_adder cell.
// Operands are consumed LSB first, one bit per clock; results update only on completion.

module full_adder (
    input  logic x_i,
    input  logic y_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic w_p;

    assign w_p = x_i ^ y_i;
    assign s_o = w_p ^ c_i;
    assign c_o = (x_i & y_i) | (w_p & c_i);

endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e r_state;
    state_e w_state_d;

    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic             r_cy;
    logic [CntW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_full_adder (
        .x_i (r_a_sr[0]),
        .y_i (r_b_sr[0]),
        .c_i (r_cy),
        .s_o (w_s),
        .c_o (w_c)
    );

    assign w_last   = (r_cnt == CntW'(WIDTH - 1));
    assign w_s_next = {w_s, r_s_sr[WIDTH-1:1]};

    // DONE also samples start_i so a held request gives one addition per WIDTH+1 cycles.
    assign w_load   = start_i && ((r_state == StIdle) || (r_state == StDone));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  w_state_d = start_i ? StRun : StIdle;
            StRun:   w_state_d = w_last ? StDone : StRun;
            StDone:  w_state_d = start_i ? StRun : StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (r_state == StRun);
        done_o = (r_state == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a_sr <= '0;
            r_b_sr <= '0;
            r_s_sr <= '0;
            r_cy   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_load) begin
            r_a_sr <= a_i;
            r_b_sr <= b_i;
            r_cy   <= cin_i;
            r_cnt  <= '0;
        end else if (r_state == StRun) begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_s_sr <= w_s_next;
            r_cy   <= w_c;
            r_cnt  <= r_cnt + CntW'(1);
        end
    end

    // Overflow: carry into the MSB (still in r_cy) differs from carry out of it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if ((r_state == StRun) && w_last) begin
            r_sum  <= w_s_next;
            r_cout <= w_c;
            r_ovf  <= r_cy ^ w_c;
        end
    end

    assign sum_o  = r_sum;
    assign cout_o = r_cout;
    assign ovf_o  = r_ovf;

endmodule
